keypad_scan_debounce: RTL and testbench
=======================================

Name: keypad_scan_debounce

Overview:
- Upstream stage of the keypad path: drives the 4x4 matrix keypad columns, samples the rows, debounces one key, and produces the key index plus a held "pressed" level.
- Its outputs feed the register bank write port (address, write enable), the PWM frequency select and the bell gate.
- Adds a single-cycle press strobe, so downstream logic no longer needs to clock on the level signal.

Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven during scanning (1 ms at 50 MHz).
- DEBOUNCE_CYC, 1000000: consecutive stable cycles required to accept a press or a release (20 ms at 50 MHz).
- SYNC_STAGES, 2: synchronizer flops on the row inputs (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- fila  input  4  keypad rows. Active-high; external pull-downs.
- col  output  4  keypad column drive. One-hot, active-high.
- posicion  output  4  debounced key index = row*4 + col_index, range 0..15.
- opr  output  1  high while the debounced key is held.
- press_stb  output  1  one-cycle pulse, asserted in the same cycle opr rises.

Behaviour:
- Reset values (async on rst=0): col=4'b0001, posicion=0, opr=0, press_stb=0, FSM=SCAN, all counters=0.
- fila passes through SYNC_STAGES flops. All decisions use the synchronized value (fs).
- Row priority: if several fs bits are set, the lowest index wins. Row index r is a 2-bit encode of that bit.
- FSM states and transitions:
  - SCAN:
    - div counter counts 0..SCAN_DIV-1.
    - At terminal count: col rotates left (0001->0010->0100->1000->0001), counter clears.
    - If fs != 0 and the counter is at least SYNC_STAGES+1 (settling guard): capture cand_row=r and cand_col=current column index, clear the debounce counter, go to DB_PRESS. col freezes.
  - DB_PRESS:
    - Each cycle the row bit cand_row is 1: debounce counter increments.
    - If that row bit reads 0: return to SCAN. col stays, div counter clears.
    - When the counter reaches DEBOUNCE_CYC-1 with the row still 1: posicion<=cand_row*4+cand_col, opr<=1, press_stb<=1 for one cycle, go to HELD.
  - HELD:
    - col frozen; opr stays 1.
    - When row bit cand_row reads 0: clear the debounce counter, go to DB_RELEASE.
    - Other keys are ignored (no rollover).
  - DB_RELEASE:
    - Row bit 0: counter increments.
    - Row bit 1: counter clears, stay in DB_RELEASE. opr remains 1.
    - At DEBOUNCE_CYC-1: opr<=0, advance col one step, clear the div counter, go to SCAN.
- posicion holds its last value after release. It changes only on an accepted press.
- Latency: press_stb is asserted exactly DEBOUNCE_CYC cycles after entering DB_PRESS. Entry is SYNC_STAGES+1 or more cycles after a stable row edge inside the driven column window.
- A press shorter than DEBOUNCE_CYC produces no strobe and no opr.
- A release glitch shorter than DEBOUNCE_CYC keeps opr=1 and produces no second strobe.
- Reset mid-press: outputs return to reset values immediately. A key still held after reset deasserts is re-detected through SCAN/DB_PRESS and strobes once.
- Counter widths: $clog2 of the parameter. No wrap is possible because compares are against terminal values.

Decomposition:
- Shared package `keypad_pkg`:
  - FSM state enum (SCAN, DB_PRESS, HELD, DB_RELEASE).
  - Constants KP_ROWS=4 and KP_COLS=4.
  - Function key_index(row, col).
- One natural sub-module: `sync_ff` (parameterised-depth, parameterised-width synchronizer), used for fila.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=16, SYNC_STAGES=2):
- Reset then idle 40 cycles with fila=0 -> col rotates 0001,0010,0100,1000,0001 every 4 cycles; opr=0, press_stb=0, posicion=0.
- Model key row 2, col 1 (fila[2]=1 only while col=0010), held 100 cycles -> press_stb exactly one cycle, opr=1, posicion=9, col frozen at 0010. Strobe occurs 16 cycles after DB_PRESS entry.
- Same key held only 10 cycles -> no strobe, opr stays 0, scanning resumes.
- Key row 3, col 3 held, then a 5-cycle release glitch, then held 50 more, then released -> one strobe, posicion=15. opr drops only 16 cycles after the final release; col then advances to 0001.
- Rows 1 and 3 both asserted on col 0 -> posicion=4 (lowest row wins).
- Assert rst=0 during HELD with the key held, then release rst -> opr=0, posicion=0, col=0001 immediately. After re-detection: exactly one new strobe and posicion restored.

Source files
------------

// File: rtl/keypad_scan_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types, constants and helpers for the keypad scanner.
//                - kp_state_t : scanner FSM state encoding
//                - KP_ROWS / KP_COLS : matrix geometry
//                - key_index() : row/column pair to linear key number
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } kp_state_t;

    // row*4 + col, which for a 4-column matrix is plain concatenation.
    function automatic logic [3:0] key_index(input logic [1:0] row,
                                             input logic [1:0] col);
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_if
//  Description : Keypad matrix and debounced-key bundle.
//                fila      : row sense inputs (active-high)
//                col       : one-hot column drive
//                posicion  : debounced key index 0..15
//                opr       : high while the debounced key is held
//                press_stb : one-cycle pulse when opr rises
//                master = scanner side, slave = keypad/consumer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_if;
    import keypad_pkg::*;

    logic [KP_ROWS-1:0] fila;
    logic [KP_COLS-1:0] col;
    logic [3:0]         posicion;
    logic               opr;
    logic               press_stb;

    modport master (
        input  fila,
        output col,
        output posicion,
        output opr,
        output press_stb
    );

    modport slave (
        output fila,
        input  col,
        input  posicion,
        input  opr,
        input  press_stb
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_debounce_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : Multi-flop synchronizer of configurable depth and width.
//                clk, rst (async active-low), d (async input), q (synced).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/keypad_scan_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_debounce
//  Description : 4x4 matrix keypad scanner with single-key debounce.
//                Rotates a one-hot column drive, samples synchronized rows,
//                debounces press and release, and reports the key index,
//                a held level and a one-cycle press strobe.
//                clk : system clock
//                rst : asynchronous active-low reset
//                kp  : keypad_if.master (fila in; col/posicion/opr/press_stb out)
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    // Rows sampled right after a column change still reflect the previous
    // column until the synchronizer has flushed; ignore them until then.
    localparam int SETTLE = SYNC_STAGES + 1;

    logic [KP_ROWS-1:0] fs;

    kp_state_t          state,     state_nxt;
    logic [KP_COLS-1:0] col,       col_nxt;
    logic [DIV_W-1:0]   div_cnt,   div_nxt;
    logic [DB_W-1:0]    db_cnt,    db_nxt;
    logic [1:0]         cand_row,  cand_row_nxt;
    logic [1:0]         cand_col,  cand_col_nxt;
    logic [3:0]         posicion,  posicion_nxt;
    logic               opr,       opr_nxt;
    logic               press_stb, press_stb_nxt;

    logic [1:0]         row_enc;
    logic [1:0]         col_enc;
    logic               row_bit;
    logic [KP_COLS-1:0] col_rot;

    sync_ff #(
        .WIDTH  (KP_ROWS),
        .STAGES (SYNC_STAGES)
    ) u_sync_fila (
        .clk (clk),
        .rst (rst),
        .d   (kp.fila),
        .q   (fs)
    );

    // Lowest active row wins when several are pressed together.
    always_comb begin
        row_enc = 2'd0;
        if      (fs[0]) row_enc = 2'd0;
        else if (fs[1]) row_enc = 2'd1;
        else if (fs[2]) row_enc = 2'd2;
        else if (fs[3]) row_enc = 2'd3;
    end

    always_comb begin
        col_enc = 2'd0;
        case (col)
            4'b0001: col_enc = 2'd0;
            4'b0010: col_enc = 2'd1;
            4'b0100: col_enc = 2'd2;
            4'b1000: col_enc = 2'd3;
            default: col_enc = 2'd0;
        endcase
    end

    assign row_bit = fs[cand_row];
    assign col_rot = {col[KP_COLS-2:0], col[KP_COLS-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            col       <= 4'b0001;
            div_cnt   <= '0;
            db_cnt    <= '0;
            cand_row  <= 2'd0;
            cand_col  <= 2'd0;
            posicion  <= 4'd0;
            opr       <= 1'b0;
            press_stb <= 1'b0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            div_cnt   <= div_nxt;
            db_cnt    <= db_nxt;
            cand_row  <= cand_row_nxt;
            cand_col  <= cand_col_nxt;
            posicion  <= posicion_nxt;
            opr       <= opr_nxt;
            press_stb <= press_stb_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        div_nxt       = div_cnt;
        db_nxt        = db_cnt;
        cand_row_nxt  = cand_row;
        cand_col_nxt  = cand_col;
        posicion_nxt  = posicion;
        opr_nxt       = opr;
        press_stb_nxt = 1'b0;

        case (state)
            SCAN: begin
                // Detection takes precedence over the terminal-count rotate
                // so a key seen in the last cycle of a window is not lost.
                if ((fs != '0) && (32'(div_cnt) >= 32'(SETTLE))) begin
                    cand_row_nxt = row_enc;
                    cand_col_nxt = col_enc;
                    db_nxt       = '0;
                    state_nxt    = DB_PRESS;
                end else if (div_cnt == DIV_LAST) begin
                    col_nxt = col_rot;
                    div_nxt = '0;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end

            DB_PRESS: begin
                if (!row_bit) begin
                    div_nxt   = '0;
                    state_nxt = SCAN;
                end else if (db_cnt == DB_LAST) begin
                    posicion_nxt  = key_index(cand_row, cand_col);
                    opr_nxt       = 1'b1;
                    press_stb_nxt = 1'b1;
                    state_nxt     = HELD;
                end else begin
                    db_nxt = db_cnt + 1'b1;
                end
            end

            HELD: begin
                if (!row_bit) begin
                    db_nxt    = '0;
                    state_nxt = DB_RELEASE;
                end
            end

            DB_RELEASE: begin
                // Any bounce back to pressed restarts the release window.
                if (row_bit) begin
                    db_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    opr_nxt   = 1'b0;
                    col_nxt   = col_rot;
                    div_nxt   = '0;
                    state_nxt = SCAN;
                end else begin
                    db_nxt = db_cnt + 1'b1;
                end
            end

            default: state_nxt = SCAN;
        endcase
    end

    assign kp.col       = col;
    assign kp.posicion  = posicion;
    assign kp.opr       = opr;
    assign kp.press_stb = press_stb;
endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan_debounce
//  Description : Self-checking bench for keypad_scan_debounce with a
//                behavioural 4x4 key matrix (fila derived from col).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_debounce;
    import keypad_pkg::*;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CYC = 16;
    localparam int SYNC_STAGES  = 2;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c held

    int n_checks = 0;
    int n_pass   = 0;

    keypad_if kp ();

    keypad_scan_debounce #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] matrix(input logic [15:0] k, input logic [3:0] c);
        logic [3:0] f;
        f = '0;
        for (int r = 0; r < 4; r++) f[r] = |(k[r*4 +: 4] & c);
        return f;
    endfunction

    assign kp.fila = matrix(keys, kp.col);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Wait (bounded) for the next press strobe.
    task automatic wait_strobe(input string name);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (kp.press_stb) got = 1'b1;
        end
        check(name, got, 1'b1);
    endtask

    // Wait (bounded) for opr to fall after keys have been released.
    task automatic wait_idle(input string name, inout int stb);
        for (int c = 0; c < 60 && kp.opr; c++) begin
            @(negedge clk);
            if (kp.press_stb) stb++;
        end
        check(name, kp.opr, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] keys;
        int          hold;
        int          exp_strobes;
        logic [3:0]  exp_pos;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   stb;
        logic seen_opr;
        int   opr_low;

        vecs[0] = '{keys: 16'h0200, hold: 100, exp_strobes: 1, exp_pos: 4'd9};
        vecs[1] = '{keys: 16'h0200, hold: 10,  exp_strobes: 0, exp_pos: 4'd9};
        vecs[2] = '{keys: 16'h1010, hold: 100, exp_strobes: 1, exp_pos: 4'd4};
        vecs[3] = '{keys: 16'h0001, hold: 100, exp_strobes: 1, exp_pos: 4'd0};
        vecs[4] = '{keys: 16'h8000, hold: 100, exp_strobes: 1, exp_pos: 4'd15};
        vecs[5] = '{keys: 16'h0040, hold: 3,   exp_strobes: 0, exp_pos: 4'd15};

        // ---- reset values and idle column rotation ----
        @(negedge clk);
        check("rst_col",  kp.col,       4'b0001);
        check("rst_pos",  kp.posicion,  4'd0);
        check("rst_opr",  kp.opr,       1'b0);
        check("rst_stb",  kp.press_stb, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            logic [3:0] exp_col;
            @(negedge clk);
            exp_col = 4'b0001 << ((k / 4) % 4);
            check("idle_col", kp.col, exp_col);
            check("idle_outs", {kp.opr, kp.press_stb, kp.posicion}, 6'd0);
        end

        // ---- exact press latency, frozen column, release timing ----
        // Key 9 (row 2, col 1): col=0010 after edge 4, fs valid after edge 6,
        // DB_PRESS entered at edge 8, strobe at edge 8+16=24.
        do_reset();
        keys = 16'h0200;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            check("lat_stb", kp.press_stb, (k == 24) ? 1'b1 : 1'b0);
            check("lat_opr", kp.opr,       (k >= 24) ? 1'b1 : 1'b0);
            if (k == 12 || k == 60) check("lat_col_frozen", kp.col, 4'b0010);
        end
        check("lat_pos", kp.posicion, 4'd9);
        // Release after edge 60: fs low after 62, DB_RELEASE at 63, drop at 79.
        keys = '0;
        for (int k = 61; k <= 80; k++) begin
            @(negedge clk);
            if (k == 78) check("rel_opr_still", kp.opr, 1'b1);
            if (k == 79) begin
                check("rel_opr_drop", kp.opr, 1'b0);
                check("rel_col_adv",  kp.col, 4'b0100);
            end
        end

        // ---- release glitch on key 15 ----
        keys = 16'h8000;
        wait_strobe("glitch_first_stb");
        stb = 0;
        opr_low = 0;
        for (int c = 0; c < 75; c++) begin
            if (c == 20) keys = '0;
            if (c == 25) keys = 16'h8000;
            @(negedge clk);
            if (kp.press_stb) stb++;
            if (!kp.opr) opr_low++;
        end
        check("glitch_no_2nd_stb", stb, 0);
        check("glitch_opr_held",   opr_low, 0);
        check("glitch_pos",        kp.posicion, 4'd15);
        // Already in DB_RELEASE: counter cleared at q+2, reaches 15 at q+17.
        keys = '0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (j == 17) check("glitch_opr_before_drop", kp.opr, 1'b1);
            if (j == 18) begin
                check("glitch_opr_drop", kp.opr, 1'b0);
                check("glitch_col_wrap", kp.col, 4'b0001);
            end
        end
        repeat (4) @(negedge clk);

        // ---- table-driven presses ----
        for (int i = 0; i < 6; i++) begin
            stb = 0;
            seen_opr = 1'b0;
            keys = vecs[i].keys;
            for (int c = 0; c < vecs[i].hold; c++) begin
                @(negedge clk);
                if (kp.press_stb) stb++;
                if (kp.opr) seen_opr = 1'b1;
            end
            keys = '0;
            wait_idle("vec_idle_timeout", stb);
            check("vec_strobes", stb, vecs[i].exp_strobes);
            check("vec_opr_seen", seen_opr, (vecs[i].exp_strobes > 0) ? 1'b1 : 1'b0);
            check("vec_pos", kp.posicion, vecs[i].exp_pos);
        end

        // ---- reset while HELD, key remains pressed ----
        keys = 16'h0200;
        wait_strobe("mid_rst_first_stb");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_opr", kp.opr,       1'b0);
        check("mid_rst_pos", kp.posicion,  4'd0);
        check("mid_rst_col", kp.col,       4'b0001);
        check("mid_rst_stb", kp.press_stb, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stb = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (kp.press_stb) stb++;
        end
        check("redetect_strobes", stb, 1);
        check("redetect_pos",     kp.posicion, 4'd9);
        check("redetect_opr",     kp.opr, 1'b1);
        keys = '0;
        stb = 0;
        wait_idle("redetect_idle_timeout", stb);
        check("redetect_no_extra_stb", stb, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
